// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master round-robin arbiter and transaction sequencer
// for the shared memory-mapped IO bus. Master 0 is the core data port,
// master 1 the accelerator DMA/control port.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | bus free; arbitrate between master requests and latch the winner
// ACCESS | io_req high with the latched command; wait for io_ready or timeout
// RESP   | one-cycle completion: owner's gnt (+err) pulse, priority flips
module io_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_gnt,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_gnt,
    output logic                  m1_err,

    output logic                  io_req,
    output logic                  io_we,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] io_rdata,
    input  logic                  io_ready,

    output logic                  busy,
    output logic                  owner
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  load;
    logic                  sel;
    logic                  done;
    logic                  timeout;
    logic                  cnt_inc;

    logic                  rr_ptr;
    logic                  owner_q;
    logic [CNT_W-1:0]      cnt;
    logic                  err_q;
    logic                  io_we_q;
    logic [ADDR_WIDTH-1:0] io_addr_q;
    logic [DATA_WIDTH-1:0] io_wdata_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;
    logic [DATA_WIDTH-1:0] resp_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    load      = 1'b1;
                    // Contention goes to whoever was not served last.
                    sel       = (m0_req && m1_req) ? rr_ptr : m1_req;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (io_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    done      = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_inc   = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's command and identity when leaving IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
        end else if (load) begin
            owner_q    <= sel;
            io_we_q    <= sel ? m1_we    : m0_we;
            io_addr_q  <= sel ? m1_addr  : m0_addr;
            io_wdata_q <= sel ? m1_wdata : m0_wdata;
        end
    end

    // Stall counter: cleared per transaction, saturates at its last value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (cnt_inc && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Writes and timed-out accesses return zero read data.
    assign resp_data = (io_ready && !io_we_q) ? io_rdata : '0;

    // Completion status, presented during RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (done) begin
            err_q <= timeout;
        end
    end

    // Per-master read data, only touched on that master's completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (done) begin
            if (owner_q) begin
                m1_rdata_q <= resp_data;
            end else begin
                m0_rdata_q <= resp_data;
            end
        end
    end

    // Round-robin pointer: after a grant the other master gets priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (state == ST_RESP) begin
            rr_ptr <= ~owner_q;
        end
    end

    // All outputs decode from registers, so io_req has no path from m*_req.
    assign io_req   = (state == ST_ACCESS);
    assign busy     = (state == ST_ACCESS) || (state == ST_RESP);
    assign m0_gnt   = (state == ST_RESP) && !owner_q;
    assign m1_gnt   = (state == ST_RESP) &&  owner_q;
    assign m0_err   = m0_gnt && err_q;
    assign m1_err   = m1_gnt && err_q;
    assign owner    = owner_q;
    assign io_we    = io_we_q;
    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: transaction-timeline reference model with a
// per-cycle compare, directed scenarios with literal expectations, then
// randomized masters, peripheral latencies and resets.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     m_req;
    logic [1:0]     m_we;
    logic [AW-1:0]  m_addr  [2];
    logic [DW-1:0]  m_wdata [2];
    logic [DW-1:0]  io_rdata;
    logic           io_ready;

    logic [DW-1:0]  m0_rdata, m1_rdata;
    logic           m0_gnt, m1_gnt, m0_err, m1_err;
    logic           io_req, io_we, busy, owner;
    logic [AW-1:0]  io_addr;
    logic [DW-1:0]  io_wdata;

    io_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m_req[0]),
        .m0_we    (m_we[0]),
        .m0_addr  (m_addr[0]),
        .m0_wdata (m_wdata[0]),
        .m0_rdata (m0_rdata),
        .m0_gnt   (m0_gnt),
        .m0_err   (m0_err),
        .m1_req   (m_req[1]),
        .m1_we    (m_we[1]),
        .m1_addr  (m_addr[1]),
        .m1_wdata (m_wdata[1]),
        .m1_rdata (m1_rdata),
        .m1_gnt   (m1_gnt),
        .m1_err   (m1_err),
        .io_req   (io_req),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ready (io_ready),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, described by its start
    // cycle, grant cycle and peripheral latency. Cycle c begins at edge c.
    int            cyc;
    bit            md_seen;
    int            md_s, md_e, md_free, md_lat;
    bit            md_own, md_prio, md_err_x;
    logic          md_we;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_wdata;
    logic [DW-1:0] md_rd [2];
    logic [DW-1:0] md_rd_pend;
    bit            e_ioreq, e_busy, e_gnt0, e_gnt1;

    int            lat_force    = -1;
    bit            rd_force_en  = 1'b0;
    logic [DW-1:0] rd_force_val = '0;

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60)      return int'($urandom_range(0, 2));
        else if (r < 85) return int'($urandom_range(3, T - 2));
        else             return int'($urandom_range(T - 1, T + 2));
    endfunction

    // Advance the model by the edge just passed, compare all outputs, then drive the peripheral
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; md_seen = 0; md_s = 0; md_e = 0; md_free = 1; md_lat = 0;
            md_own = 0; md_prio = 0; md_err_x = 0;
            md_we = 0; md_addr = '0; md_wdata = '0;
            md_rd[0] = '0; md_rd[1] = '0; md_rd_pend = '0;
        end else begin
            cyc = cyc + 1;
            if (cyc >= md_free && m_req != 2'b00) begin
                md_own   = (m_req == 2'b11) ? md_prio : m_req[1];
                md_we    = m_we[md_own];
                md_addr  = m_addr[md_own];
                md_wdata = m_wdata[md_own];
                md_lat   = (lat_force >= 0) ? lat_force : pick_lat();
                md_s     = cyc;
                md_e     = cyc + ((md_lat < T) ? md_lat + 1 : T);
                md_err_x = (md_lat >= T);
                md_free  = md_e + 2;
                md_seen  = 1;
                md_rd_pend = '0;
            end
            if (md_seen && cyc == md_e) begin
                md_rd[md_own] = (md_err_x || md_we) ? '0 : md_rd_pend;
                md_prio = ~md_own;
            end
        end
        e_ioreq = md_seen && cyc >= md_s && cyc < md_e;
        e_busy  = md_seen && cyc >= md_s && cyc <= md_e;
        e_gnt0  = md_seen && cyc == md_e && !md_own;
        e_gnt1  = md_seen && cyc == md_e && md_own;

        chk("io_req",   io_req,   e_ioreq);
        chk("busy",     busy,     e_busy);
        chk("m0_gnt",   m0_gnt,   e_gnt0);
        chk("m1_gnt",   m1_gnt,   e_gnt1);
        chk("m0_err",   m0_err,   e_gnt0 && md_err_x);
        chk("m1_err",   m1_err,   e_gnt1 && md_err_x);
        chk("owner",    owner,    md_own);
        chk("io_we",    io_we,    md_we);
        chk("io_addr",  io_addr,  md_addr);
        chk("io_wdata", io_wdata, md_wdata);
        chk("m0_rdata", m0_rdata, md_rd[0]);
        chk("m1_rdata", m1_rdata, md_rd[1]);

        if (!rst && e_ioreq) begin
            io_ready = (cyc == md_s + md_lat);
            io_rdata = rd_force_en ? rd_force_val : $urandom;
            if (io_ready) md_rd_pend = io_rdata;
        end else begin
            io_ready = 1'($urandom_range(0, 1));
            io_rdata = $urandom;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [1:0] pend;
    logic       g0, g1, gi;
    int         n_ioreq;

    task automatic random_phase(input int ncycles);
        for (int k = 0; k < ncycles; k++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1; m_req = 2'b00; pend = 2'b00;
                step();
                rst = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                gi = (i == 0) ? e_gnt0 : e_gnt1;
                if (pend[i]) begin
                    if (gi) begin
                        m_req[i] = 1'b0;
                        pend[i]  = 1'b0;
                    end else if (e_ioreq && md_own == 1'(i) && $urandom_range(0, 9) == 0) begin
                        m_req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i]    = 1'b1;
                    m_req[i]   = 1'b1;
                    m_we[i]    = 1'($urandom_range(0, 1));
                    m_addr[i]  = $urandom;
                    m_wdata[i] = $urandom;
                end
            end
        end
    endtask

    // Bound the run even if the clocking or stimulus misbehaves
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        rst = 1'b1; m_req = 2'b00; m_we = 2'b00; pend = 2'b00;
        m_addr[0] = '0; m_addr[1] = '0; m_wdata[0] = '0; m_wdata[1] = '0;
        repeat (3) step();
        chk("rst_io_req", io_req, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_owner",  owner,  0);
        chk("rst_gnt",    {m0_gnt, m1_gnt, m0_err, m1_err}, 0);

        // Both masters requesting: m0, m1, m0, m1, m0 every 3 cycles
        lat_force = 0;
        rst = 1'b0;
        m_req = 2'b11; m_we = 2'b00;
        m_addr[0] = 32'h1000_0100; m_addr[1] = 32'h1000_0200;
        for (int j = 1; j <= 15; j++) begin
            step();
            g0 = (j == 2 || j == 8 || j == 14);
            g1 = (j == 5 || j == 11);
            chk("rr_m0_gnt", m0_gnt, g0);
            chk("rr_m1_gnt", m1_gnt, g1);
            chk("rr_owner",  owner,  ((j - 1) / 3) % 2);
            m_req[0] = !g0 && (j < 14);
            m_req[1] = !g1 && (j < 11);
        end

        // m0 read, peripheral answers at once with 0xA5
        rd_force_en = 1'b1; rd_force_val = 32'h0000_00A5;
        m_we[0] = 1'b0; m_addr[0] = 32'h1000_0000; m_req[0] = 1'b1;
        step();
        chk("rd_io_req",  io_req,  1);
        chk("rd_io_addr", io_addr, 32'h1000_0000);
        chk("rd_io_we",   io_we,   0);
        step();
        chk("rd_m0_gnt",   m0_gnt,   1);
        chk("rd_m0_rdata", m0_rdata, 32'h0000_00A5);
        chk("rd_m0_err",   m0_err,   0);
        m_req[0] = 1'b0;
        rd_force_en = 1'b0;
        step();

        // m1 write with three stall cycles
        lat_force = 3;
        m_we[1] = 1'b1; m_addr[1] = 32'h1000_1004; m_wdata[1] = 32'hDEAD_BEEF; m_req[1] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("wr_m0_gnt", m0_gnt, 0);
            if (j <= 4) begin
                chk("wr_io_req",   io_req,   1);
                chk("wr_io_addr",  io_addr,  32'h1000_1004);
                chk("wr_io_wdata", io_wdata, 32'hDEAD_BEEF);
                chk("wr_io_we",    io_we,    1);
            end
            if (j == 5) begin
                chk("wr_m1_gnt",   m1_gnt,   1);
                chk("wr_m1_err",   m1_err,   0);
                chk("wr_m1_rdata", m1_rdata, 0);
                m_req[1] = 1'b0;
            end
            if (j == 6) chk("wr_idle_io_req", io_req, 0);
        end

        // m0 read of an unmapped address: no io_ready ever, timeout abort
        lat_force = T + 5;
        m_we[0] = 1'b0; m_addr[0] = 32'h2000_0000; m_req[0] = 1'b1;
        n_ioreq = 0;
        for (int j = 1; j <= T + 3; j++) begin
            step();
            n_ioreq += int'(io_req);
            chk("to_m0_gnt", m0_gnt, (j == T + 1));
            if (j == T + 1) begin
                chk("to_m0_err",   m0_err,   1);
                chk("to_m0_rdata", m0_rdata, 0);
                m_req[0] = 1'b0;
            end
        end
        chk("to_io_req_cycles", n_ioreq, 16);

        // Give m1 nonzero read data so the reset clearing is visible
        lat_force = 0; rd_force_en = 1'b1; rd_force_val = 32'h0000_5A5A;
        m_we[1] = 1'b0; m_addr[1] = 32'h1000_2000; m_req[1] = 1'b1;
        step();
        step();
        chk("pre_m1_rdata", m1_rdata, 32'h0000_5A5A);
        m_req[1] = 1'b0;
        rd_force_en = 1'b0;
        step();

        // Reset in the 2nd ACCESS cycle of an m0 read while m1 is pending
        lat_force = 5;
        m_we[0] = 1'b0; m_addr[0] = 32'h3000_0000; m_req[0] = 1'b1;
        step();
        m_we[1] = 1'b0; m_addr[1] = 32'h3000_0004; m_req[1] = 1'b1;
        step();
        chk("mid_io_req_before", io_req, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_io_req",   io_req,   0);
        chk("mid_rst_busy",     busy,     0);
        chk("mid_rst_io_addr",  io_addr,  0);
        chk("mid_rst_m1_rdata", m1_rdata, 0);
        chk("mid_rst_gnt",      {m0_gnt, m1_gnt}, 0);
        m_req[0] = 1'b0;
        step();
        chk("mid_rst_gnt_hold", {m0_gnt, m1_gnt}, 0);
        lat_force = 0;
        rst = 1'b0;
        step();
        chk("post_owner",   owner,   1);
        chk("post_io_addr", io_addr, 32'h3000_0004);
        m_req[0] = 1'b1;
        step();
        chk("post_m1_gnt", m1_gnt, 1);
        chk("post_m0_gnt", m0_gnt, 0);
        m_req[1] = 1'b0;
        step();
        step();
        chk("post_m0_io_addr", io_addr, 32'h3000_0000);
        step();
        chk("post_m0_gnt2", m0_gnt, 1);
        m_req[0] = 1'b0;
        step();

        // Randomized traffic against the model
        lat_force = -1;
        pend = 2'b00;
        random_phase(4000);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
